// File: rtl/fifo_word_serializer.sv
// Read-side stage for the fifo block: pops wide words through the rd/q/mty port and
// streams them out as OUT_WIDTH slices on valid/ready, marking the final slice of each word.
module fifo_word_serializer #(
   parameter int IN_WIDTH  = 128,
   parameter int OUT_WIDTH = 32,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic                 clk,
   input  logic                 arst_n,
   input  logic                 srst,
   input  logic                 fifo_mty,
   output logic                 fifo_rd,
   input  logic [IN_WIDTH-1:0]  fifo_q,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last,
   output logic                 busy
);

   localparam int RATIO = IN_WIDTH / OUT_WIDTH;
   localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      SHIFT = 2'd2
   } state_t;

   state_t                            state, state_nxt;
   logic [CNT_W-1:0]                  cnt, cnt_nxt;
   logic [IN_WIDTH-1:0]               word_reg, word_nxt;
   logic                              accept;
   logic                              last_slice;
   logic [RATIO-1:0][OUT_WIDTH-1:0]   slices;
   logic [OUT_WIDTH-1:0]              slice_sel;

   // Slice ordering is fixed at elaboration; index 0 is always the first slice sent.
   genvar gi;
   generate
      for (gi = 0; gi < RATIO; gi++) begin : g_slice
         if (MSB_FIRST) begin : g_msb
            assign slices[gi] = word_reg[(RATIO-1-gi)*OUT_WIDTH +: OUT_WIDTH];
         end else begin : g_lsb
            assign slices[gi] = word_reg[gi*OUT_WIDTH +: OUT_WIDTH];
         end
      end
   endgenerate

   always_comb begin
      slice_sel = '0;
      for (int i = 0; i < RATIO; i++) begin
         if (cnt == CNT_W'(i)) slice_sel = slices[i];
      end
   end

   assign out_valid  = (state == SHIFT);
   assign last_slice = (cnt == CNT_LAST);
   assign accept     = out_valid & out_ready;
   assign out_last   = out_valid & last_slice;
   assign out_data   = out_valid ? slice_sel : '0;
   assign busy       = (state != IDLE);

   // The next read overlaps the last-slice accept so only one WAIT bubble separates words.
   assign fifo_rd = !srst && !fifo_mty &&
                    ((state == IDLE) || ((state == SHIFT) && last_slice && accept));

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      word_nxt  = word_reg;
      if (srst) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
         word_nxt  = '0;
      end else begin
         case (state)
            IDLE: begin
               if (fifo_rd) state_nxt = WAIT;
            end
            WAIT: begin
               state_nxt = SHIFT;
               word_nxt  = fifo_q;
               cnt_nxt   = '0;
            end
            SHIFT: begin
               if (accept) begin
                  if (last_slice) begin
                     state_nxt = fifo_rd ? WAIT : IDLE;
                     cnt_nxt   = '0;
                  end else begin
                     cnt_nxt = cnt + CNT_W'(1);
                  end
               end
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         word_reg <= '0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         word_reg <= word_nxt;
      end
   end

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Scoreboard bench: two serializers (LSB-first and MSB-first) share one FIFO model and one
// consumer; stimulus queues hand-computed slices, a monitor pops them on every accept.
module tb_fifo_word_serializer;

   localparam int IW = 128;
   localparam int OW = 32;

   typedef struct packed {
      logic [OW-1:0] data;
      logic          last;
   } exp_t;

   logic          clk = 1'b0;
   logic          arst_n = 1'b0;
   logic          srst = 1'b0;
   logic          out_ready = 1'b1;
   logic          fifo_mty = 1'b1;
   logic [IW-1:0] fifo_q = '0;
   logic          push_en = 1'b0;
   logic [IW-1:0] push_data = '0;

   logic          fifo_rd0, fifo_rd1;
   logic [OW-1:0] out_data0, out_data1;
   logic          out_valid0, out_valid1;
   logic          out_last0, out_last1;
   logic          busy0, busy1;

   exp_t          exp0[$];
   exp_t          exp1[$];
   logic [IW-1:0] mem[$];
   int            n_pass = 0;
   int            n_tot = 0;
   int            rd_cnt = 0;

   always #5 clk = ~clk;

   fifo_word_serializer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .MSB_FIRST(1'b0)) dut0 (
      .clk(clk), .arst_n(arst_n), .srst(srst), .fifo_mty(fifo_mty), .fifo_rd(fifo_rd0),
      .fifo_q(fifo_q), .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready),
      .out_last(out_last0), .busy(busy0));

   fifo_word_serializer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .MSB_FIRST(1'b1)) dut1 (
      .clk(clk), .arst_n(arst_n), .srst(srst), .fifo_mty(fifo_mty), .fifo_rd(fifo_rd1),
      .fifo_q(fifo_q), .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
      .out_last(out_last1), .busy(busy1));

   // FIFO model with registered read data, driven by dut0's strobe
   always @(posedge clk) begin
      if (fifo_rd0 && mem.size() > 0) fifo_q <= mem.pop_front();
      if (push_en) mem.push_back(push_data);
      fifo_mty <= (mem.size() == 0);
   end

   task automatic chk(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(negedge clk);
      push_en = 1'b0;
   endtask

   // s0..s3 are the LSB-first slices of the word
   task automatic load(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2,
                       input logic [31:0] s3, input bit track);
      @(negedge clk);
      push_en   = 1'b1;
      push_data = {s3, s2, s1, s0};
      if (track) begin
         exp0.push_back('{s0, 1'b0}); exp0.push_back('{s1, 1'b0});
         exp0.push_back('{s2, 1'b0}); exp0.push_back('{s3, 1'b1});
         exp1.push_back('{s3, 1'b0}); exp1.push_back('{s2, 1'b0});
         exp1.push_back('{s1, 1'b0}); exp1.push_back('{s0, 1'b1});
      end
   endtask

   task automatic drain(input string name);
      out_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         tick();
         #1;
         if (exp0.size() == 0 && !busy0) break;
      end
      chk(name, {exp0.size() == 0, busy0}, 2'b10);
   endtask

   // Monitor: scoreboard pops, stall stability, read accounting
   initial begin
      logic          stall_prev;
      logic [OW-1:0] d0_prev, d1_prev;
      logic          l0_prev;
      exp_t          e;
      stall_prev = 1'b0;
      d0_prev = '0; d1_prev = '0; l0_prev = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (!arst_n) begin
            stall_prev = 1'b0;
            continue;
         end
         if (fifo_rd0 || fifo_rd1) begin
            chk("rd_match", fifo_rd1, fifo_rd0);
            if (fifo_rd0) rd_cnt++;
            chk("rd_while_mty", fifo_mty, 1'b0);
         end
         if (out_valid0 || out_valid1) chk("valid_match", out_valid1, out_valid0);
         if (out_valid0 && stall_prev) begin
            chk("stall_data0", out_data0, d0_prev);
            chk("stall_data1", out_data1, d1_prev);
            chk("stall_last", out_last0, l0_prev);
         end
         if (out_valid0 && out_ready) begin
            if (exp0.size() == 0) begin
               n_tot++;
               $display("FAIL sb0_extra: got slice %h with empty scoreboard", out_data0);
            end else begin
               e = exp0.pop_front();
               chk("sb0_slice", {out_data0, out_last0}, {e.data, e.last});
            end
            if (exp1.size() == 0) begin
               n_tot++;
               $display("FAIL sb1_extra: got slice %h with empty scoreboard", out_data1);
            end else begin
               e = exp1.pop_front();
               chk("sb1_slice", {out_data1, out_last1}, {e.data, e.last});
            end
         end
         stall_prev = out_valid0 && !out_ready;
         d0_prev = out_data0; d1_prev = out_data1; l0_prev = out_last0;
      end
   end

   initial begin
      int nv;
      int base;
      logic [7:0] bp_pat;
      nv = 0; base = 0; bp_pat = 8'b1001_1001;

      // reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_outputs0", {fifo_rd0, out_valid0, out_last0, busy0}, 4'b0);
      chk("rst_data0", out_data0, 32'h0);
      chk("rst_data1", out_data1, 32'h0);
      @(negedge clk);
      arst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(); #1;
         chk("empty_quiet", {fifo_rd0, out_valid0, busy0}, 3'b0);
      end

      // single word, latency and last marking
      load(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 1'b1);
      tick(); #1; chk("w1_rd_N", fifo_rd0, 1'b1);
      tick(); #1; chk("w1_wait", {out_valid0, busy0, fifo_rd0}, 3'b010);
      for (int k = 0; k < 4; k++) begin
         tick(); #1;
         chk("w1_slice", {out_valid0, out_last0, fifo_rd0}, {1'b1, k == 3, 1'b0});
         if (k == 0) chk("w1_first_lsb", out_data0, 32'h11111111);
         if (k == 0) chk("w1_first_msb", out_data1, 32'h44444444);
      end
      tick(); #1; chk("w1_idle", {out_valid0, busy0}, 2'b00);

      // two words back to back: 8 slices in 9 cycles
      load(32'ha0a0a0a0, 32'ha1a1a1a1, 32'ha2a2a2a2, 32'ha3a3a3a3, 1'b1);
      load(32'hb0000000, 32'hb0000001, 32'hb0000002, 32'hb0000003, 1'b1);
      #1; chk("b2b_rd_N", fifo_rd0, 1'b1);
      tick(); #1; chk("b2b_wait", {out_valid0, busy0}, 2'b01);
      for (int k = 2; k <= 10; k++) begin
         tick(); #1;
         nv += int'(out_valid0);
         if (k == 5) chk("b2b_rd_at_last", {fifo_rd0, out_last0}, 2'b11);
         if (k == 6) chk("b2b_bubble", {out_valid0, busy0}, 2'b01);
      end
      chk("b2b_8_in_9", nv, 8);
      tick(); #1; chk("b2b_idle", {out_valid0, busy0}, 2'b00);

      // consumer stalled indefinitely: first word held, no further reads
      base = rd_cnt;
      load(32'hc0c0c0c0, 32'hc1c1c1c1, 32'hc2c2c2c2, 32'hc3c3c3c3, 1'b1);
      out_ready = 1'b0;
      load(32'hd0d0d0d0, 32'hd1d1d1d1, 32'hd2d2d2d2, 32'hd3d3d3d3, 1'b1);
      repeat (20) tick();
      #1;
      chk("hold_state", {out_valid0, out_last0, busy0}, 3'b101);
      chk("hold_data", out_data0, 32'hc0c0c0c0);
      chk("hold_one_rd", rd_cnt - base, 1);
      drain("hold_drain");
      chk("hold_two_rd", rd_cnt - base, 2);

      // random backpressure
      base = rd_cnt;
      load(32'h0e000001, 32'h0e000002, 32'h0e000003, 32'h0e000004, 1'b1);
      load(32'h0f000001, 32'h0f000002, 32'h0f000003, 32'h0f000004, 1'b1);
      load(32'h10000001, 32'h10000002, 32'h10000003, 32'h10000004, 1'b1);
      for (int i = 0; i < 300; i++) begin
         tick();
         out_ready = (i < 8) ? bp_pat[7 - i] : 1'($urandom_range(0, 1));
         #1;
         if (exp0.size() == 0 && !busy0) break;
      end
      chk("bp_done", {exp0.size() == 0, busy0}, 2'b10);
      out_ready = 1'b1;
      chk("bp_rd_per_word", rd_cnt - base, 3);

      // srst during WAIT discards the word in flight
      load(32'hdeadbeef, 32'hdeadbeef, 32'hdeadbeef, 32'hdeadbeef, 1'b0);
      tick(); #1; chk("srst_rd_N", fifo_rd0, 1'b1);
      tick(); srst = 1'b1; #1; chk("srst_wait", {fifo_rd0, busy0}, 2'b01);
      tick(); srst = 1'b0; #1;
      chk("srst_cleared", {out_valid0, busy0, fifo_rd0, out_last0}, 4'b0);
      chk("srst_data", out_data0, 32'h0);

      // srst forces fifo_rd low even with a word waiting
      load(32'h5a5a0000, 32'h5a5a0001, 32'h5a5a0002, 32'h5a5a0003, 1'b1);
      tick(); srst = 1'b1; #1; chk("srst_blocks_rd", fifo_rd0, 1'b0);
      tick(); srst = 1'b0; #1; chk("srst_release_rd", fifo_rd0, 1'b1);
      drain("srst_drain");

      // async reset mid-SHIFT at cnt=2: word lost
      load(32'h77770000, 32'h77770001, 32'h77770002, 32'h77770003, 1'b1);
      repeat (4) tick();
      tick(); #1;
      chk("arst_pre", {out_valid0, out_last0, out_data0}, {1'b1, 1'b0, 32'h77770002});
      arst_n = 1'b0;
      #1;
      chk("arst_async", {out_valid0, out_last0, busy0, fifo_rd0}, 4'b0);
      chk("arst_sb_left", exp0.size(), 2);
      exp0.delete();
      exp1.delete();
      tick(); arst_n = 1'b1; #1;
      chk("arst_after", {out_valid0, busy0, fifo_rd0}, 3'b0);
      chk("arst_data", out_data0, 32'h0);
      repeat (3) tick();
      #1; chk("arst_quiet", {out_valid0, busy0}, 2'b00);
      chk("sb_empty_end", exp1.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
